rv_fetch_queue: RTL and testbench
=================================

Name: rv_fetch_queue

Overview:
- Parametrised, decoupled instruction-fetch stage for the pipelined RV32 core.
- Replaces the fixed PC register, +4 adder and IF/ID latch with three parts:
  - a request/grant/response instruction-memory port;
  - a DEPTH-entry prefetch queue of {pc, inst, pc+4};
  - a valid/ready handshake toward decode.
- Adds two behaviours: redirect-with-kill of in-flight fetches, and halt that drains cleanly.

Parameters:
- XLEN, 32: address/instruction width.
- DEPTH, 4: queue entries; power of two, >= 2.
- RESET_PC, 0: fetch address after reset.
- NOP_INST, 32'h00000033: bubble encoding (add x0,x0,x0) driven on out_inst when empty.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address; bits [1:0] always 0.
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  XLEN  fetched instruction.
- redirect  in  1  taken branch/jal/jalr from EX: flush and refetch.
- redirect_pc  in  XLEN  new fetch target; bits [1:0] ignored (forced 0).
- halt  in  1  stop issuing new fetches (ecall/ebreak/halt decode).
- out_valid  out  1  queue head valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  XLEN  head PC.
- out_inst  out  XLEN  head instruction; NOP_INST when out_valid=0.
- out_pc4  out  XLEN  head PC+4.
- count  out  clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset values (one clock with rst=1):
  - fetch_pc=RESET_PC; queue empty; count=0.
  - out_valid=0; out_inst=NOP_INST; out_pc=out_pc4=0.
  - pending=0; kill=0; imem_req=0 in the cycle following reset.
- Reset mid-operation discards everything; an imem_rvalid arriving while pending=0 is ignored.
- Request issue:
  - imem_req = !rst & !halt & !redirect & (!pending | imem_rvalid) & (count + pending < DEPTH).
  - count and pending are registered values; at most one fetch is outstanding.
  - imem_addr = fetch_pc (registered).
  - On imem_req & imem_gnt: pending<=1, pend_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^XLEN wrap).
  - imem_req stays high until granted; imem_addr is stable while ungranted.
- Response:
  - On imem_rvalid & pending: pending<=0 unless a new grant occurs in the same cycle.
  - If kill=0, push {pend_pc, imem_rdata, pend_pc+4}.
  - If kill=1, discard the response and clear kill.
- Latency: grant in cycle N, rvalid in N+1, out_valid in N+2 (queue registered).
- Sustained throughput is 1 instruction/cycle with 1-cycle memory and out_ready=1.
- Output:
  - out_valid = (count != 0); head fields are driven from storage.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle: count unchanged, FIFO order preserved.
- Full: push with count==DEPTH is impossible by the issue rule. The design carries an assertion that fires if it occurs.
- Redirect has highest priority after rst:
  - count<=0; read/write pointers reset; fetch_pc<=redirect_pc.
  - No request issued in the redirect cycle.
  - A response arriving in the redirect cycle is discarded.
  - If pending=1 and no rvalid this cycle, kill<=1.
  - A pop in the redirect cycle still counts as accepted by decode; the queue is cleared regardless.
- Redirect while kill=1: kill stays 1; fetch_pc takes the newest redirect_pc.
- Halt:
  - Blocks new requests only; an outstanding response is still pushed and the queue drains normally.
  - On deassert, fetching resumes at fetch_pc.
  - Redirect during halt updates fetch_pc and flushes.

Test Plan:
- Reset and stream, RESET_PC=0, gnt=1, 1-cycle memory returning inst=addr|0x13, out_ready=1:
  - imem_addr 0,4,8,… one per cycle.
  - out_pc 0,4,8… starting 2 cycles after first grant; out_pc4=out_pc+4.
  - out_inst=NOP_INST before the first valid.
- Backpressure, out_ready=0:
  - count climbs to 4 and imem_req drops with fetch_pc=0x10.
  - Then ready=1: out_pc 0,4,8,C in consecutive cycles, fetching resumes at 0x10 with no gap or duplicate.
- Kill of in-flight fetch, memory latency 3 cycles:
  - Redirect to 0x100 one cycle after grant of 0x8; the stale 0x8 response is dropped.
  - Next issued address and first out_pc are both 0x100.
- Simultaneous redirect, rvalid and pop, count=2:
  - Redirect_pc=0x40 in the same cycle: count=0 next cycle, no push.
  - Next out_pc=0x40; redirect_pc=0x43 also yields 0x40.
- Halt: assert with one fetch pending at 0x20.
  - 0x20 is pushed and delivered; no further imem_req.
  - After deassert, the next address is 0x24.
- Wrap and mid-operation reset:
  - RESET_PC=0xFFFFFFFC: addresses FFFFFFFC then 0.
  - rst asserted while pending, with rvalid the cycle after: queue stays empty, out_valid=0, next address = RESET_PC.

Source files
------------

// File: rtl/rv_fetch_queue.sv
// Decoupled RV32 instruction-fetch stage: one-outstanding request/grant/response
// memory port feeding a DEPTH-entry prefetch queue with a valid/ready decode side.
module rv_fetch_queue #(
  parameter int unsigned      XLEN     = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [XLEN-1:0]  NOP_INST = XLEN'(32'h0000_0033),
  localparam int unsigned     CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc4,
  output logic [CW-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_pending;
  logic            r_kill;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;

  logic [XLEN-1:0] r_q_pc   [DEPTH];
  logic [XLEN-1:0] r_q_inst [DEPTH];
  logic [XLEN-1:0] r_q_pc4  [DEPTH];

  logic [CW:0]     w_inflight;
  logic            w_grant;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;

  // Issue is gated on registered occupancy plus the outstanding fetch, so a
  // response can never find the queue full even if decode never pops.
  assign w_inflight = {1'b0, r_count} + (CW + 1)'(r_pending);
  assign imem_req   = !rst && !halt && !redirect
                   && (!r_pending || imem_rvalid)
                   && (w_inflight < (CW + 1)'(DEPTH));
  assign imem_addr  = r_fetch_pc;

  assign w_grant       = imem_req && imem_gnt;
  assign w_resp        = r_pending && imem_rvalid;
  assign w_push        = w_resp && !r_kill && !redirect;
  assign out_valid     = (r_count != '0);
  assign w_pop         = out_valid && out_ready;
  assign count         = r_count;
  assign w_redirect_pc = redirect_pc & ~XLEN'(3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= '0;
      r_pending  <= 1'b0;
      r_kill     <= 1'b0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect) begin
      // A fetch still in flight must have its response dropped when it lands.
      r_fetch_pc <= w_redirect_pc;
      r_pending  <= r_pending && !imem_rvalid;
      r_kill     <= r_pending && !imem_rvalid;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      if (w_grant) begin
        r_pending  <= 1'b1;
        r_pend_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end else if (w_resp) begin
        r_pending  <= 1'b0;
      end
      if (w_resp) r_kill <= 1'b0;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // NOTE: queue storage is deliberately not reset; r_count alone says which
  // entries hold live data, and the head mux hides stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_pend_pc;
      r_q_inst[r_wr_ptr] <= imem_rdata;
      r_q_pc4[r_wr_ptr]  <= r_pend_pc + XLEN'(4);
    end
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    out_pc   = '0;
    out_inst = NOP_INST;
    out_pc4  = '0;
    if (out_valid) begin
      out_pc   = r_q_pc[r_rd_ptr];
      out_inst = r_q_inst[r_rd_ptr];
      out_pc4  = r_q_pc4[r_rd_ptr];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Self-checking bench for rv_fetch_queue: directed scenarios plus a randomized
// run checked against a program-order PC model.
module tb_rv_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_gnt = 1'b1, imem_rvalid = 1'b0, redirect = 1'b0, halt = 1'b0, out_ready = 1'b0;
  logic [31:0] imem_rdata = '0, redirect_pc = '0;
  logic        imem_req, out_valid;
  logic [31:0] imem_addr, out_pc, out_inst, out_pc4;
  logic [2:0]  count;
  logic        w_imem_req, w_out_valid;
  logic [31:0] w_imem_addr, w_out_pc, w_out_inst, w_out_pc4;
  logic [2:0]  w_count;

  int n_checks = 0;
  int n_fail   = 0;

  rv_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP_INST(NOP)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_pc4(out_pc4), .count(count));

  // Second instance only to observe a RESET_PC at the top of the address space.
  rv_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) u_dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_pc(w_out_pc), .out_inst(w_out_inst), .out_pc4(w_out_pc4), .count(w_count));

  always #5 clk = ~clk;

  // Memory model: each granted address answers mem_lat cycles later with addr|0x13.
  typedef struct { logic [31:0] addr; int due; } resp_t;
  resp_t mq[$];
  int    cyc = 0;
  int    mem_lat = 1;

  always @(posedge clk) begin
    resp_t r;
    if (imem_req && imem_gnt) begin
      r.addr = imem_addr;
      r.due  = cyc + mem_lat;
      mq.push_back(r);
    end
    cyc++;
    #1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr | 32'h13;
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // Leaves rst=1 at a falling edge after two reset clocks; caller releases it.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; halt = 1'b0; out_ready = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mq.delete();
  endtask

  task automatic test_reset();
    mem_lat = 1;
    do_reset();
    #1;
    n_checks++;
    if ({out_valid, out_pc, out_inst, out_pc4, count} !== {1'b0, 32'h0, NOP, 32'h0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b pc=%h inst=%h pc4=%h cnt=%0d exp v=0 pc=0 inst=%h pc4=0 cnt=0",
               out_valid, out_pc, out_inst, out_pc4, count, NOP);
    end
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_req: got req=%0b addr=%h exp req=0 addr=0", imem_req, imem_addr);
    end
    n_checks++;
    if (w_imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL reset_pc_param: got %h exp fffffffc", w_imem_addr);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, w_imem_req} !== 2'b11) begin
      n_fail++;
      $display("FAIL first_req: got %b exp 11", {imem_req, w_imem_req});
    end
    @(negedge clk); #1;
    n_checks++;
    if ({imem_addr, w_imem_addr} !== {32'h4, 32'h0}) begin
      n_fail++;
      $display("FAIL addr_wrap: got %h/%h exp 00000004/00000000", imem_addr, w_imem_addr);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({w_out_valid, w_out_pc, w_out_pc4} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++;
      $display("FAIL pc4_wrap: got v=%0b pc=%h pc4=%h exp v=1 pc=fffffffc pc4=0", w_out_valid, w_out_pc, w_out_pc4);
    end
  endtask

  task automatic test_stream();
    logic [96:0] got, exp;
    logic [31:0] p;
    mem_lat = 1;
    do_reset();
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_checks++;
      if ({imem_req, imem_addr} !== {1'b1, 32'(4 * k)}) begin
        n_fail++;
        $display("FAIL stream_addr[%0d]: got req=%0b addr=%h exp req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
      end
      p   = 32'(4 * (k - 2));
      got = {out_valid, out_pc, out_inst, out_pc4};
      exp = (k < 2) ? {1'b0, 32'h0, NOP, 32'h0} : {1'b1, p, p | 32'h13, p + 32'h4};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL stream_out[%0d]: got %h exp %h", k, got, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    mem_lat = 1;
    do_reset();
    rst = 1'b0; out_ready = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    n_checks++;
    if ({count, imem_req, imem_addr, out_valid, out_pc} !== {3'd4, 1'b0, 32'h10, 1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL bp_full: got cnt=%0d req=%0b addr=%h v=%0b pc=%h exp cnt=4 req=0 addr=10 v=1 pc=0",
               count, imem_req, imem_addr, out_valid, out_pc);
    end
    out_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      if (r > 0) begin @(negedge clk); #1; end
      n_checks++;
      if ({out_valid, out_pc, out_inst} !== {1'b1, 32'(4 * r), 32'(4 * r) | 32'h13}) begin
        n_fail++;
        $display("FAIL bp_drain[%0d]: got v=%0b pc=%h inst=%h exp pc=%h", r, out_valid, out_pc, out_inst, 32'(4 * r));
      end
    end
  endtask

  task automatic test_kill();
    bit found = 0, got_a = 0, got_o = 0;
    logic [31:0] first_a = '0, first_o = '0;
    mem_lat = 3;
    do_reset();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (imem_req && imem_gnt && imem_addr == 32'h8) begin found = 1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL kill_grant8: got no grant of 8 exp grant within 40 cycles"); end
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL kill_no_req: got %0b exp 0", imem_req); end
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      #1;
      if (!got_a && imem_req && imem_gnt) begin got_a = 1; first_a = imem_addr; end
      if (!got_o && out_valid) begin got_o = 1; first_o = out_pc; end
      if (got_a && got_o) break;
    end
    n_checks++;
    if ({got_a, first_a} !== {1'b1, 32'h100}) begin
      n_fail++; $display("FAIL kill_next_addr: got seen=%0b addr=%h exp 100", got_a, first_a);
    end
    n_checks++;
    if ({got_o, first_o} !== {1'b1, 32'h100}) begin
      n_fail++; $display("FAIL kill_first_out: got seen=%0b pc=%h exp 100", got_o, first_o);
    end
  endtask

  task automatic test_simul(input logic [31:0] rpc);
    bit found = 0;
    mem_lat = 1;
    do_reset();
    rst = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (count == 3'd2 && imem_rvalid) begin found = 1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL simul_setup: got no count=2 with rvalid exp within 20 cycles"); end
    redirect = 1'b1; redirect_pc = rpc; out_ready = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, out_pc, imem_req} !== {1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL simul_redirect_cycle: got v=%0b pc=%h req=%0b exp v=1 pc=0 req=0", out_valid, out_pc, imem_req);
    end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    n_checks++;
    if ({count, out_valid, out_inst} !== {3'd0, 1'b0, NOP}) begin
      n_fail++; $display("FAIL simul_flushed: got cnt=%0d v=%0b inst=%h exp cnt=0 v=0 nop", count, out_valid, out_inst);
    end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin found = 1; break; end
      @(negedge clk); #1;
    end
    n_checks++;
    if ({found, out_pc, out_inst, out_pc4} !== {1'b1, 32'h40, 32'h53, 32'h44}) begin
      n_fail++; $display("FAIL simul_target(%h): got v=%0b pc=%h inst=%h pc4=%h exp pc=40 inst=53 pc4=44",
                         rpc, found, out_pc, out_inst, out_pc4);
    end
  endtask

  task automatic test_halt();
    bit found = 0, saw_req = 0, saw20 = 0;
    mem_lat = 2;
    do_reset();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (imem_req && imem_gnt && imem_addr == 32'h20) begin found = 1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL halt_setup: got no grant of 20 exp within 60 cycles"); end
    @(negedge clk);
    halt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      saw_req = saw_req | imem_req;
      if (out_valid && out_ready && out_pc == 32'h20) saw20 = 1;
    end
    n_checks++;
    if ({saw_req, saw20, count} !== {1'b0, 1'b1, 3'd0}) begin
      n_fail++; $display("FAIL halt_drain: got req_seen=%0b pc20_seen=%0b cnt=%0d exp 0 1 0", saw_req, saw20, count);
    end
    @(negedge clk);
    halt = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h24}) begin
      n_fail++; $display("FAIL halt_resume: got req=%0b addr=%h exp req=1 addr=24", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] g [3];
    int  ng = 0;
    bit  saw_fc = 0;
    mem_lat = 1;
    do_reset();
    rst = 1'b0; out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      redirect = 1'b0;
      #1;
      if (imem_req && imem_gnt && ng < 3) begin g[ng] = imem_addr; ng++; end
      if (out_valid && out_pc == 32'hFFFF_FFFC) begin
        saw_fc = 1;
        n_checks++;
        if ({out_inst, out_pc4} !== {32'hFFFF_FFFF, 32'h0}) begin
          n_fail++; $display("FAIL wrap_head: got inst=%h pc4=%h exp ffffffff 0", out_inst, out_pc4);
        end
      end
    end
    n_checks++;
    if ({ng == 3, g[0], g[1], g[2]} !== {1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0}) begin
      n_fail++; $display("FAIL wrap_addrs: got n=%0d %h %h %h exp fffffff8 fffffffc 0", ng, g[0], g[1], g[2]);
    end
    n_checks++;
    if (!saw_fc) begin n_fail++; $display("FAIL wrap_seen: got no head at fffffffc exp one"); end
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    mem_lat = 2;
    do_reset();
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (imem_req && imem_gnt && imem_addr == 32'h8) begin found = 1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL mrst_setup: got no grant of 8 exp within 30 cycles"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({imem_rvalid, imem_req, imem_addr, count, out_valid} !== {1'b1, 1'b1, 32'h0, 3'd0, 1'b0}) begin
      n_fail++; $display("FAIL mrst_after: got rv=%0b req=%0b addr=%h cnt=%0d v=%0b exp 1 1 0 0 0",
                         imem_rvalid, imem_req, imem_addr, count, out_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({count, out_valid, out_inst} !== {3'd0, 1'b0, NOP}) begin
      n_fail++; $display("FAIL mrst_ignored: got cnt=%0d v=%0b inst=%h exp 0 0 nop", count, out_valid, out_inst);
    end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin found = 1; break; end
      @(negedge clk); #1;
    end
    n_checks++;
    if ({found, out_pc} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL mrst_first_out: got v=%0b pc=%h exp pc=0", found, out_pc);
    end
  endtask

  // Decode must see an unbroken +4 sequence restarting at each redirect target.
  task automatic test_random();
    logic [31:0] exp_pc = 32'h0, prev_addr = '0;
    bit  prev_wait = 0;
    int  pops = 0;
    mem_lat = 1;
    do_reset();
    rst = 1'b0;
    for (int c = 0; c < 1200; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 100 == 0) mem_lat = int'($urandom_range(1, 3));
      out_ready   = ($urandom_range(0, 3) != 0);
      imem_gnt    = ($urandom_range(0, 3) != 0);
      halt        = ($urandom_range(0, 9) == 0);
      redirect    = ($urandom_range(0, 29) == 0);
      redirect_pc = $urandom;
      #1;
      if (prev_wait) begin
        n_checks++;
        if (imem_addr !== prev_addr) begin
          n_fail++; $display("FAIL rnd_addr_stable[%0d]: got %h exp %h", c, imem_addr, prev_addr);
        end
      end
      n_checks++;
      if (imem_addr[1:0] !== 2'b00 || count > 3'd4 || (!out_valid && out_inst !== NOP)) begin
        n_fail++; $display("FAIL rnd_invariant[%0d]: got addr=%h cnt=%0d v=%0b inst=%h exp aligned, cnt<=4, nop when empty",
                           c, imem_addr, count, out_valid, out_inst);
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if ({out_pc, out_inst, out_pc4} !== {exp_pc, exp_pc | 32'h13, exp_pc + 32'h4}) begin
          n_fail++; $display("FAIL rnd_pop[%0d]: got pc=%h inst=%h pc4=%h exp pc=%h", c, out_pc, out_inst, out_pc4, exp_pc);
        end
        exp_pc = exp_pc + 32'h4;
        pops++;
      end
      if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      prev_wait = imem_req && !imem_gnt;
      prev_addr = imem_addr;
    end
    @(negedge clk);
    halt = 1'b0; redirect = 1'b0;
    n_checks++;
    if (pops < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d pops exp >= 100", pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_kill();
    test_simul(32'h40);
    test_simul(32'h43);
    test_halt();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
